// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window sequencer.
// Holds pixel/result widths, the sequencer state encoding and patch indexing.
package conv_pkg;
  localparam int PIX_W = 16;
  localparam int RES_W = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CALC  = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Row-major position of window element (r, c) inside a K x K patch.
  function automatic int patch_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction
endpackage

// File: rtl/conv_window_sequencer_if.sv
// Pixel RAM read port plus the result stream of the window sequencer.
// The master modport is the sequencer side; the slave modport is RAM + sink.
interface conv_window_sequencer_if
  import conv_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rd_data;

  // Result stream: a beat transfers on a clock edge where res_valid && res_ready.
  // Once res_valid rises, res_data/res_row/res_col stay stable until that edge.
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic [15:0]       res_row;
  logic [15:0]       res_col;

  modport master (
    output mem_rd_en, mem_addr, res_valid, res_data, res_row, res_col,
    input  mem_rd_data, res_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, res_valid, res_data, res_row, res_col,
    output mem_rd_data, res_ready
  );
endinterface

// File: rtl/conv_addr_gen.sv
// Window position counters (row/col) and in-window offset counters (r/c).
// Produces the pixel RAM address of the current fetch and the last-window flag.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step_off,
  input  logic              step_win,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       row,
  output logic [15:0]       col,
  output logic              last_win
);
  logic [15:0] r_q, c_q, row_q, col_q;
  logic [31:0] addr_full;

  assign addr_full = (32'(row_q) + 32'(r_q)) * 32'(IMG_W) + 32'(col_q) + 32'(c_q);
  assign addr      = addr_full[ADDR_W-1:0];
  assign row       = row_q;
  assign col       = col_q;
  assign last_win  = (row_q == 16'(IMG_H - KERNEL_SIZE)) && (col_q == 16'(IMG_W - KERNEL_SIZE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      c_q   <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (clear) begin
      r_q   <= '0;
      c_q   <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      // Offsets wrap back to (0,0) after the last element, ready for the next window.
      if (step_off) begin
        if (c_q == 16'(KERNEL_SIZE - 1)) begin
          c_q <= '0;
          r_q <= (r_q == 16'(KERNEL_SIZE - 1)) ? 16'd0 : r_q + 16'd1;
        end else begin
          c_q <= c_q + 16'd1;
        end
      end
      if (step_win) begin
        if (col_q == 16'(IMG_W - KERNEL_SIZE)) begin
          col_q <= '0;
          if (!last_win) row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
    end
  end
endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every stride-1 K x K window of the image, fetches its patch from the
// pixel RAM, registers the external datapath's sum and streams it out.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int ADDR_W      = 10
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  input  logic                                          kernel_we,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]    kernel_idx,
  input  logic [PIX_W-1:0]                              kernel_wdata,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIX_W-1:0]      patch_o,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIX_W-1:0]      kernel_o,
  input  logic [RES_W-1:0]                              conv_result_i,
  conv_window_sequencer_if.master                       bus,
  output state_t                                        state_dbg
);
  localparam int NPIX = KERNEL_SIZE * KERNEL_SIZE;
  localparam int FW   = $clog2(NPIX + 1);
  localparam int KIW  = $clog2(NPIX);

  state_t                  state_q, state_d;
  logic [FW-1:0]           fcnt_q;
  logic                    rd_en, step_win, clear, last_win;
  logic [ADDR_W-1:0]       gen_addr;
  logic [15:0]             row, col;
  logic [NPIX*PIX_W-1:0]   patch_q, kernel_q;
  logic [RES_W-1:0]        res_data_q;
  logic [15:0]             res_row_q, res_col_q;

  conv_addr_gen #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .ADDR_W      (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .step_off (rd_en),
    .step_win (step_win),
    .addr     (gen_addr),
    .row      (row),
    .col      (col),
    .last_win (last_win)
  );

  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    step_win = 1'b0;
    clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = FETCH;
        end
      end
      // Reads go out on counts 0..NPIX-1; the final count only lands the last pixel.
      FETCH: begin
        rd_en = (fcnt_q != FW'(NPIX));
        if (fcnt_q == FW'(NPIX)) state_d = CALC;
      end
      CALC: state_d = OUT;
      OUT: begin
        if (bus.res_ready) begin
          step_win = 1'b1;
          state_d  = last_win ? FIN : FETCH;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fcnt_q     <= '0;
      patch_q    <= '0;
      kernel_q   <= '0;
      res_data_q <= '0;
      res_row_q  <= '0;
      res_col_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && fcnt_q != FW'(NPIX)) fcnt_q <= fcnt_q + FW'(1);
      else                                         fcnt_q <= '0;
      // Read data for element n returns one cycle after its strobe, at count n+1.
      if (state_q == FETCH) begin
        for (int i = 0; i < NPIX; i++) begin
          if (fcnt_q == FW'(i + 1)) patch_q[i*PIX_W +: PIX_W] <= bus.mem_rd_data;
        end
      end
      if (state_q == CALC) begin
        res_data_q <= conv_result_i;
        res_row_q  <= row;
        res_col_q  <= col;
      end
      // Weights only change while idle, so a pass always sees one kernel.
      if (state_q == IDLE && kernel_we) begin
        for (int i = 0; i < NPIX; i++) begin
          if (kernel_idx == KIW'(i)) kernel_q[i*PIX_W +: PIX_W] <= kernel_wdata;
        end
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign state_dbg     = state_q;
  assign patch_o       = patch_q;
  assign kernel_o      = kernel_q;
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_en ? gen_addr : '0;
  assign bus.res_valid = (state_q == OUT);
  assign bus.res_data  = res_data_q;
  assign bus.res_row   = res_row_q;
  assign bus.res_col   = res_col_q;
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer on a 4x4 image with a 3x3 kernel.
// A reference model fills a queue of expected results popped on each stream beat.
module tb_conv_window_sequencer;
  import conv_pkg::*;

  localparam int K  = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 10;
  localparam int NP = K * K;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               kernel_we = 1'b0;
  logic [3:0]         kernel_idx = '0;
  logic [15:0]        kernel_wdata = '0;
  logic               busy, done;
  logic [NP*16-1:0]   patch_o, kernel_o;
  logic [63:0]        conv_result;
  state_t             state_dbg;

  logic [15:0]        img [W*H];
  logic [15:0]        kern_m [NP];
  logic [95:0]        exp_q [$];
  int                 n_vec = 0;
  int                 n_err = 0;

  conv_window_sequencer_if #(.ADDR_W(AW)) bus();

  conv_window_sequencer #(
    .KERNEL_SIZE (K),
    .IMG_W       (W),
    .IMG_H       (H),
    .ADDR_W      (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .kernel_we     (kernel_we),
    .kernel_idx    (kernel_idx),
    .kernel_wdata  (kernel_wdata),
    .patch_o       (patch_o),
    .kernel_o      (kernel_o),
    .conv_result_i (conv_result),
    .bus           (bus),
    .state_dbg     (state_dbg)
  );

  // Clock and the external blocks: pixel RAM with 1-cycle read, combinational MAC.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= img[int'(bus.mem_addr)];
  end

  always_comb begin
    conv_result = '0;
    for (int i = 0; i < NP; i++)
      conv_result = conv_result + 64'(patch_o[i*16 +: 16]) * 64'(kernel_o[i*16 +: 16]);
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NP*16-1:0] kpack();
    logic [NP*16-1:0] v;
    for (int i = 0; i < NP; i++) v[i*16 +: 16] = kern_m[i];
    return v;
  endfunction

  task automatic build_expected();
    logic [63:0] sum;
    for (int r0 = 0; r0 <= H - K; r0++) begin
      for (int c0 = 0; c0 <= W - K; c0++) begin
        sum = '0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            sum = sum + 64'(img[(r0 + r) * W + c0 + c]) * 64'(kern_m[patch_idx(r, c, K)]);
        exp_q.push_back({16'(r0), 16'(c0), sum});
      end
    end
  endtask

  task automatic load_kernel(input int idx, input logic [15:0] val);
    @(negedge clk);
    kernel_we    = 1'b1;
    kernel_idx   = 4'(idx);
    kernel_wdata = val;
    @(negedge clk);
    kernel_we = 1'b0;
    if (idx < NP) kern_m[idx] = val;
  endtask

  task automatic run_pass(input bit rand_ready, input bit hold_first, input bit interfere,
                          input bit same_kwe, input int kidx, input logic [15:0] kval);
    int          hold_cnt = 0;
    int          done_cnt = 0;
    int          n_res = 0;
    int          last_hs = -1;
    int          n_exp;
    bit          fin = 1'b0;
    logic [95:0] e;
    if (same_kwe && kidx < NP) kern_m[kidx] = kval;
    build_expected();
    n_exp = exp_q.size();
    @(negedge clk);
    start = 1'b1;
    if (same_kwe) begin
      kernel_we    = 1'b1;
      kernel_idx   = 4'(kidx);
      kernel_wdata = kval;
    end
    @(negedge clk);
    start     = 1'b0;
    kernel_we = 1'b0;
    check("busy_after_start", 96'(busy), 96'd1);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done) begin
        done_cnt++;
        fin       = 1'b1;
        start     = 1'b0;
        kernel_we = 1'b0;
      end else if (interfere && (cyc % 5 == 2)) begin
        start        = 1'b1;
        kernel_we    = 1'b1;
        kernel_idx   = 4'($urandom_range(0, NP - 1));
        kernel_wdata = 16'($urandom);
      end else begin
        start     = 1'b0;
        kernel_we = 1'b0;
      end
      if (hold_first && hold_cnt < 5) begin
        bus.res_ready = 1'b0;
        if (bus.res_valid) begin
          check("hold_valid", 96'(bus.res_valid), 96'd1);
          check("hold_data", 96'(bus.res_data), 96'(exp_q[0][63:0]));
          check("hold_pos", 96'({bus.res_row, bus.res_col}), 96'(exp_q[0][95:64]));
          check("hold_no_read", 96'(bus.mem_rd_en), 96'd0);
          hold_cnt++;
        end
      end else begin
        bus.res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!bus.mem_rd_en) check("addr_idle_zero", 96'(bus.mem_addr), 96'd0);
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 96'd1, 96'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", 96'(bus.res_data), 96'(e[63:0]));
          check("res_pos", 96'({bus.res_row, bus.res_col}), 96'(e[95:64]));
        end
        if (!rand_ready && !hold_first && last_hs >= 0)
          check("throughput", 96'(cyc - last_hs), 96'(NP + 3));
        last_hs = cyc;
        n_res++;
      end
    end
    check("pass_finished", 96'(fin), 96'd1);
    @(negedge clk);
    check("busy_cleared", 96'(busy), 96'd0);
    check("done_pulse_width", 96'(done), 96'd0);
    check("done_count", 96'(done_cnt), 96'd1);
    check("result_count", 96'(n_res), 96'(n_exp));
    check("queue_drained", 96'(exp_q.size()), 96'd0);
    exp_q.delete();
    bus.res_ready = 1'b1;
  endtask

  initial begin
    bus.res_ready = 1'b1;
    for (int i = 0; i < W * H; i++) img[i] = '0;
    for (int i = 0; i < NP; i++) kern_m[i] = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 96'(busy), 96'd0);
    check("rst_done", 96'(done), 96'd0);
    check("rst_valid", 96'(bus.res_valid), 96'd0);
    check("rst_rd_en", 96'(bus.mem_rd_en), 96'd0);
    check("rst_addr", 96'(bus.mem_addr), 96'd0);
    check("rst_data", 96'(bus.res_data), 96'd0);
    check("rst_state", 96'(state_dbg), 96'(IDLE));
    check("rst_patch_nonzero", 96'(|patch_o), 96'd0);
    check("rst_kernel_nonzero", 96'(|kernel_o), 96'd0);
    rst_n = 1'b1;

    // All-ones image and kernel: four sums of 9
    for (int i = 0; i < W * H; i++) img[i] = 16'd1;
    for (int i = 0; i < NP; i++) load_kernel(i, 16'd1);
    check("kernel_loaded", 96'(kernel_o !== kpack()), 96'd0);
    run_pass(1'b0, 1'b0, 1'b0, 1'b0, 0, 16'd0);

    // Ramp image, one-hot centre weight written in the same cycle as start
    for (int i = 0; i < W * H; i++) img[i] = 16'(i);
    for (int i = 0; i < NP; i++) load_kernel(i, 16'd0);
    load_kernel(9, 16'h1234);
    load_kernel(15, 16'hBEEF);
    check("kernel_idx_oob_ignored", 96'(kernel_o !== kpack()), 96'd0);
    run_pass(1'b0, 1'b0, 1'b0, 1'b1, 4, 16'd1);

    // Maximum operands, sink stalls on the first result then toggles ready
    for (int i = 0; i < W * H; i++) img[i] = 16'hFFFF;
    for (int i = 0; i < NP; i++) load_kernel(i, 16'hFFFF);
    run_pass(1'b1, 1'b1, 1'b0, 1'b0, 0, 16'd0);

    // Random data, start/kernel_we pulses while busy must be ignored
    for (int i = 0; i < W * H; i++) img[i] = 16'($urandom);
    for (int i = 0; i < NP; i++) load_kernel(i, 16'($urandom));
    run_pass(1'b1, 1'b0, 1'b1, 1'b0, 0, 16'd0);
    check("kernel_stable", 96'(kernel_o !== kpack()), 96'd0);

    // Asynchronous reset in the middle of a fetch
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midfetch_reading", 96'(bus.mem_rd_en), 96'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 96'(busy), 96'd0);
    check("abort_rd_en", 96'(bus.mem_rd_en), 96'd0);
    check("abort_addr", 96'(bus.mem_addr), 96'd0);
    check("abort_state", 96'(state_dbg), 96'(IDLE));
    check("abort_kernel_nonzero", 96'(|kernel_o), 96'd0);
    check("abort_patch_nonzero", 96'(|patch_o), 96'd0);
    for (int i = 0; i < NP; i++) kern_m[i] = '0;
    repeat (2) @(negedge clk);
    check("abort_no_done", 96'(done), 96'd0);
    rst_n = 1'b1;
    for (int i = 0; i < W * H; i++) img[i] = 16'($urandom_range(0, 255));
    for (int i = 0; i < NP; i++) load_kernel(i, 16'($urandom_range(0, 255)));
    run_pass(1'b0, 1'b0, 1'b0, 1'b0, 0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
